cacheline_adaptor: RTL and testbench

Responder on the cache's physical-memory interface. It accepts a single 256-bit line read or write request from the cache and converts it into a 4-beat, 64-bit burst transaction toward DRAM or the memory model. It sits between the cache's pmem_* ports and the burst memory. It completes each line transaction with a one-cycle response to the cache.

---
 rtl/cache_types_pkg.sv | 26 ++
 rtl/line_beat_buffer.sv | 33 +++
 rtl/cacheline_adaptor.sv | 108 ++++++++++
 tb/tb_cacheline_adaptor.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and sizing constants for the cache-side memory adaptor.
package cache_types_pkg;

  localparam int S_LINE      = 256;
  localparam int S_BURST     = 64;
  localparam int NUM_BEATS   = S_LINE / S_BURST;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_BITS    = $clog2(NUM_BEATS);

  // Clears the byte-offset bits so the burst starts on a line boundary
  localparam logic [31:0] LINE_ALIGN_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } adaptor_state_t;

  // Returns the line-aligned base address of any byte address
  function automatic logic [31:0] align_line(input logic [31:0] addr);
    return addr & LINE_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide staging register: loaded whole from the cache on a write-back,
// filled one beat at a time from memory on a read, and read out per beat.
module line_beat_buffer
  import cache_types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [S_LINE-1:0]   i_line,
  input  logic                i_beat_we,
  input  logic [CNT_BITS-1:0] i_beat_idx,
  input  logic [S_BURST-1:0]  i_beat,
  output logic [S_LINE-1:0]   o_line,
  output logic [S_BURST-1:0]  o_beat
);

  logic [S_LINE-1:0] r_line;

  // A full-line load takes priority; otherwise one beat slice is overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      r_line[S_BURST*i_beat_idx +: S_BURST] <= i_beat;
    end
  end

  assign o_line = r_line;
  assign o_beat = r_line[S_BURST*i_beat_idx +: S_BURST];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read/write into a 4-beat 64-bit burst
// toward memory and answers the cache with a single-cycle response.
module cacheline_adaptor
  import cache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic [S_LINE-1:0]  line_i,
  output logic [S_LINE-1:0]  line_o,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic [31:0]        address_o,
  input  logic [S_BURST-1:0] burst_i,
  output logic [S_BURST-1:0] burst_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(NUM_BEATS - 1);

  adaptor_state_t      r_state;
  adaptor_state_t      w_next;
  logic [CNT_BITS-1:0] r_cnt;
  logic [31:0]         r_addr;
  logic                w_start;
  logic                w_load;
  logic                w_beat_we;
  logic                w_advance;
  logic [S_BURST-1:0]  w_beat;
  logic [S_LINE-1:0]   w_line;

  line_beat_buffer u_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_line     (line_i),
    .i_beat_we  (w_beat_we),
    .i_beat_idx (r_cnt),
    .i_beat     (burst_i),
    .o_line     (w_line),
    .o_beat     (w_beat)
  );

  // Next-state decode; a write request beats a simultaneous read request
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_load    = 1'b0;
    w_beat_we = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_next  = WR_BURST;
          w_start = 1'b1;
          w_load  = 1'b1;
        end else if (read_i) begin
          w_next  = RD_BURST;
          w_start = 1'b1;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          w_beat_we = 1'b1;
          if (r_cnt == LAST_BEAT) w_next = RD_DONE;
        end
      end
      RD_DONE:  w_next = IDLE;
      WR_BURST: begin
        if (resp_i && (r_cnt == LAST_BEAT)) w_next = WR_DONE;
      end
      WR_DONE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  assign w_advance = resp_i && ((r_state == RD_BURST) || (r_state == WR_BURST));

  // Latch the aligned address at transaction start; count accepted beats,
  // letting the counter wrap to zero on the final beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_addr <= align_line(address_i);
      r_cnt  <= '0;
    end else if (w_advance) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign read_o    = (r_state == RD_BURST);
  assign write_o   = (r_state == WR_BURST);
  assign resp_o    = (r_state == RD_DONE) || (r_state == WR_DONE);
  assign address_o = (r_state == IDLE) ? '0 : r_addr;
  assign burst_o   = (r_state == WR_BURST) ? w_beat : '0;
  assign line_o    = w_line;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomised self-checking bench for the cache line burst adaptor.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int vectors;
  int miscompares;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .address_o (address_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference timing: the memory strobe follows pat bit k on the k-th burst
  // cycle (all ones past bit 31); bursts start on cycle 1, the response
  // arrives one cycle after the cycle carrying the 4th strobe.
  function automatic int exp_resp_cycle(input logic [31:0] pat);
    int n = 0;
    for (int p = 0; p < 32; p++) begin
      if (pat[p]) begin
        n++;
        if (n == 4) return p + 2;
      end
    end
    return 31 + (4 - n) + 2;
  endfunction

  // Drives one line read as the cache and plays memory; reports observations
  task automatic do_read(input logic [31:0] addr, input logic [31:0] expAddr,
                         input logic [255:0] src, input logic [31:0] pat,
                         input bit drain, output logic [255:0] gotLine,
                         output int respCycle, output int respCount,
                         output int addrErr, output int wrongDir,
                         output bit timedOut);
    int beat = 0;
    int k = 0;
    bit strobe;
    read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
    gotLine = '0; respCycle = -1; respCount = 0; addrErr = 0; wrongDir = 0;
    timedOut = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      resp_i = 1'b0;
      burst_i = {$urandom, $urandom};
      if (write_o) wrongDir++;
      if (read_o) begin
        if (address_o !== expAddr) addrErr++;
        strobe = (k < 32) ? pat[k] : 1'b1;
        k++;
        if (strobe && beat < 4) begin
          resp_i = 1'b1;
          burst_i = src[64*beat +: 64];
          beat++;
        end
      end
      if (resp_o) begin
        respCount++;
        if (respCycle < 0) begin
          respCycle = c;
          gotLine = line_o;
          read_i = 1'b0;
          if (!drain) begin
            timedOut = 1'b0;
            break;
          end
          continue;
        end
      end
      if (respCycle >= 0 && c == respCycle + 1) begin
        timedOut = 1'b0;
        break;
      end
    end
    read_i = 1'b0;
    resp_i = 1'b0;
  endtask

  // Drives one line write-back as the cache and plays memory
  task automatic do_write(input logic [31:0] addr, input logic [31:0] expAddr,
                          input logic [255:0] src, input logic [31:0] pat,
                          input bit bothReq, input bit drain,
                          output logic [255:0] gotLine, output int respCycle,
                          output int respCount, output int addrErr,
                          output int wrongDir, output int holdErr,
                          output bit timedOut);
    int beat = 0;
    int k = 0;
    bit strobe;
    write_i = 1'b1; read_i = bothReq; address_i = addr; line_i = src;
    resp_i = 1'b0;
    gotLine = '0; respCycle = -1; respCount = 0; addrErr = 0; wrongDir = 0;
    holdErr = 0; timedOut = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      line_i = rand_line();
      resp_i = 1'b0;
      burst_i = {$urandom, $urandom};
      if (read_o) wrongDir++;
      if (write_o) begin
        if (address_o !== expAddr) addrErr++;
        if (beat < 4 && burst_o !== src[64*beat +: 64]) holdErr++;
        strobe = (k < 32) ? pat[k] : 1'b1;
        k++;
        if (strobe && beat < 4) begin
          resp_i = 1'b1;
          gotLine[64*beat +: 64] = burst_o;
          beat++;
        end
      end
      if (resp_o) begin
        respCount++;
        if (respCycle < 0) begin
          respCycle = c;
          write_i = 1'b0;
          read_i = 1'b0;
          if (!drain) begin
            timedOut = 1'b0;
            break;
          end
          continue;
        end
      end
      if (respCycle >= 0 && c == respCycle + 1) begin
        timedOut = 1'b0;
        break;
      end
    end
    write_i = 1'b0;
    read_i = 1'b0;
    resp_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'hDEAD_BEEF; line_i = rand_line(); burst_i = '1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (read_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_read_o: got %b expected 0", read_o); end
    vectors++; if (write_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_write_o: got %b expected 0", write_o); end
    vectors++; if (resp_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_o: got %b expected 0", resp_o); end
    vectors++; if (address_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_address_o: got %h expected 0", address_o); end
    vectors++; if (burst_o !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_burst_o: got %h expected 0", burst_o); end
    vectors++; if (line_o !== 256'h0) begin miscompares++; $display("[TB] FAIL reset_line_o: got %h expected 0", line_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (address_o !== 32'h0 || read_o !== 1'b0 || write_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_outputs: got addr %h rd %b wr %b expected 0 0 0", address_o, read_o, write_o);
    end
  endtask

  task automatic test_read_nogap();
    logic [255:0] src, got;
    int rc, cnt, ae, wd;
    bit to;
    src = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, 32'h0000_1220, src, 32'hFFFF_FFFF, 1'b1, got, rc, cnt, ae, wd, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL rd_timeout: got timeout expected resp_o"); end
    vectors++; if (got !== src) begin miscompares++; $display("[TB] FAIL rd_line: got %h expected %h", got, src); end
    vectors++; if (rc !== 5) begin miscompares++; $display("[TB] FAIL rd_latency: got %0d expected 5", rc); end
    vectors++; if (cnt !== 1) begin miscompares++; $display("[TB] FAIL rd_resp_count: got %0d expected 1", cnt); end
    vectors++; if (ae !== 0) begin miscompares++; $display("[TB] FAIL rd_address: got %0d bad cycles expected 0", ae); end
    vectors++; if (wd !== 0) begin miscompares++; $display("[TB] FAIL rd_direction: got %0d write_o cycles expected 0", wd); end
  endtask

  task automatic test_read_gaps();
    logic [255:0] src, got;
    int rc, cnt, ae, wd;
    bit to;
    src = rand_line();
    do_read(32'hABCD_EF7F, 32'hABCD_EF60, src, 32'hFFFF_FFD9, 1'b1, got, rc, cnt, ae, wd, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL gap_timeout: got timeout expected resp_o"); end
    vectors++; if (got !== src) begin miscompares++; $display("[TB] FAIL gap_line: got %h expected %h", got, src); end
    vectors++; if (rc !== 8) begin miscompares++; $display("[TB] FAIL gap_latency: got %0d expected 8", rc); end
    vectors++; if (cnt !== 1) begin miscompares++; $display("[TB] FAIL gap_resp_count: got %0d expected 1", cnt); end
    vectors++; if (ae !== 0) begin miscompares++; $display("[TB] FAIL gap_address: got %0d bad cycles expected 0", ae); end
  endtask

  task automatic test_write();
    logic [255:0] src, got;
    int rc, cnt, ae, wd, he;
    bit to;
    src = 256'h0123456789abcdef_f0e1d2c3b4a59687_1122334455667788_99aabbccddeecdef;
    do_write(32'h8000_003C, 32'h8000_0020, src, 32'hFFFF_FF6B, 1'b0, 1'b1, got, rc, cnt, ae, wd, he, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL wr_timeout: got timeout expected resp_o"); end
    vectors++; if (got !== src) begin miscompares++; $display("[TB] FAIL wr_beats: got %h expected %h", got, src); end
    vectors++; if (he !== 0) begin miscompares++; $display("[TB] FAIL wr_hold: got %0d wrong burst_o cycles expected 0", he); end
    vectors++; if (rc !== exp_resp_cycle(32'hFFFF_FF6B)) begin
      miscompares++; $display("[TB] FAIL wr_latency: got %0d expected %0d", rc, exp_resp_cycle(32'hFFFF_FF6B));
    end
    vectors++; if (cnt !== 1) begin miscompares++; $display("[TB] FAIL wr_resp_count: got %0d expected 1", cnt); end
    vectors++; if (ae !== 0) begin miscompares++; $display("[TB] FAIL wr_address: got %0d bad cycles expected 0", ae); end
  endtask

  task automatic test_simultaneous();
    logic [255:0] src, got;
    int rc, cnt, ae, wd, he;
    bit to;
    src = rand_line();
    do_write(32'h0000_0040, 32'h0000_0040, src, 32'hFFFF_FFFF, 1'b1, 1'b1, got, rc, cnt, ae, wd, he, to);
    vectors++; if (wd !== 0) begin miscompares++; $display("[TB] FAIL both_read_o: got %0d read_o cycles expected 0", wd); end
    vectors++; if (got !== src) begin miscompares++; $display("[TB] FAIL both_beats: got %h expected %h", got, src); end
    vectors++; if (rc !== 5 || cnt !== 1 || to) begin
      miscompares++; $display("[TB] FAIL both_resp: got cycle %0d count %0d expected cycle 5 count 1", rc, cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wsrc, rsrc, got;
    int rc, cnt, ae, wd, he;
    bit to;
    wsrc = rand_line();
    rsrc = ~wsrc;
    do_write(32'h1000_0100, 32'h1000_0100, wsrc, 32'hFFFF_FFFF, 1'b0, 1'b0, got, rc, cnt, ae, wd, he, to);
    vectors++; if (to || cnt !== 1 || got !== wsrc) begin
      miscompares++; $display("[TB] FAIL b2b_write: got count %0d timeout %b expected count 1 no timeout", cnt, to);
    end
    do_read(32'h2000_0208, 32'h2000_0200, rsrc, 32'hFFFF_FFF5, 1'b1, got, rc, cnt, ae, wd, to);
    vectors++; if (got !== rsrc) begin miscompares++; $display("[TB] FAIL b2b_fill: got %h expected %h", got, rsrc); end
    vectors++; if (cnt !== 1 || to) begin miscompares++; $display("[TB] FAIL b2b_read_resp: got %0d expected 1", cnt); end
    vectors++; if (rc !== exp_resp_cycle(32'hFFFF_FFF5) + 1) begin
      miscompares++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", rc, exp_resp_cycle(32'hFFFF_FFF5) + 1);
    end
    vectors++; if (wd !== 0 || ae !== 0) begin
      miscompares++; $display("[TB] FAIL b2b_read_bus: got %0d write_o %0d addr errors expected 0 0", wd, ae);
    end
  endtask

  task automatic test_reset_midburst();
    logic [255:0] src, got;
    int accepted = 0;
    int stray = 0;
    int rc, cnt, ae, wd;
    bit to;
    bit reached = 1'b0;
    src = rand_line();
    read_i = 1'b1; write_i = 1'b0; address_i = 32'h0000_5A5A; resp_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      resp_i = 1'b0;
      if (accepted == 2) begin
        reached = 1'b1;
        break;
      end
      if (read_o) begin
        resp_i = 1'b1;
        burst_i = src[64*accepted +: 64];
        accepted++;
      end
    end
    vectors++; if (!reached) begin miscompares++; $display("[TB] FAIL rst_mid_reach: got %0d beats expected 2", accepted); end
    rst = 1'b1;
    #1;
    vectors++; if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_mid_ctrl: got rd %b resp %b expected 0 0", read_o, resp_o);
    end
    vectors++; if (line_o !== 256'h0) begin miscompares++; $display("[TB] FAIL rst_mid_line: got %h expected 0", line_o); end
    vectors++; if (address_o !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_addr: got %h expected 0", address_o); end
    read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_o || read_o) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("[TB] FAIL rst_mid_stray: got %0d active cycles expected 0", stray); end
    src = rand_line();
    do_read(32'h0000_5A5A, 32'h0000_5A40, src, 32'hFFFF_FFFF, 1'b1, got, rc, cnt, ae, wd, to);
    vectors++; if (got !== src || rc !== 5 || cnt !== 1) begin
      miscompares++; $display("[TB] FAIL rst_mid_recover: got line %h cycle %0d expected line %h cycle 5", got, rc, src);
    end
  endtask

  task automatic test_random();
    logic [255:0] src, got;
    logic [31:0] addr, pat;
    int rc, cnt, ae, wd, he;
    bit to;
    for (int t = 0; t < 16; t++) begin
      src = rand_line();
      addr = $urandom;
      pat = $urandom;
      he = 0;
      if ($urandom_range(1, 0) == 1)
        do_write(addr, addr & 32'hFFFF_FFE0, src, pat, 1'b0, 1'b1, got, rc, cnt, ae, wd, he, to);
      else
        do_read(addr, addr & 32'hFFFF_FFE0, src, pat, 1'b1, got, rc, cnt, ae, wd, to);
      vectors++; if (to) begin miscompares++; $display("[TB] FAIL rnd_timeout[%0d]: got timeout expected resp_o", t); end
      vectors++; if (got !== src) begin miscompares++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", t, got, src); end
      vectors++; if (rc !== exp_resp_cycle(pat)) begin
        miscompares++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", t, rc, exp_resp_cycle(pat));
      end
      vectors++; if (cnt !== 1 || ae !== 0 || wd !== 0 || he !== 0) begin
        miscompares++; $display("[TB] FAIL rnd_bus[%0d]: got resp %0d addr %0d dir %0d hold %0d expected 1 0 0 0", t, cnt, ae, wd, he);
      end
    end
  endtask

  // Runs every scenario in order and prints the tally
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_read_nogap();
    test_read_gaps();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
